// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and the ROM/decode/testbench side.
//
// Protocol: start is a single-cycle request pulse that the sequencer accepts
// in IDLE or DONE and ignores in RUN. While running is high, PC addresses the
// combinational ROM and inst/branch_* must be valid the same cycle. stall
// holds the current instruction, so nothing retires that cycle. done high
// means the program has finished: either a halt retired or, with bounds
// checking, a fetch went out of range (fault high).
interface fetch_sequencer_if #(
  parameter int PW = 16,
  parameter int OW = 8
);
  logic          start;
  logic [8:0]    inst;
  logic          branch_en;
  logic          branch_abs;
  logic [PW-1:0] target;
  logic [OW-1:0] offset;
  logic          stall;
  logic [PW-1:0] PC;
  logic          running;
  logic          done;
  logic [15:0]   inst_count;
  logic          fault;

  modport master (
    input  start, inst, branch_en, branch_abs, target, offset, stall,
    output PC, running, done, inst_count, fault
  );

  modport slave (
    output start, inst, branch_en, branch_abs, target, offset, stall,
    input  PC, running, done, inst_count, fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter / instruction-fetch sequencer.
// PC is registered and drives a combinational ROM; the returned word is
// retired in the same cycle (no bubbles, no delay slot). Priority in RUN is
// stall > halt > branch > increment. inst_count saturates at 16'hFFFF.
// Optional macro FETCH_BOUNDS_EN: out-of-range next PC (>= PROG_LEN or a
// relative sum leaving the PW-bit range) raises fault and ends the run
// without retiring. Without it PC wraps modulo 2**PW and fault is 0.
module fetch_sequencer #(
  parameter int         PW         = 16,
  parameter int         OW         = 8,
  parameter int         START_ADDR = 0,
  parameter logic [8:0] HALT_INST  = 9'h1FF,
  parameter int         PROG_LEN   = 2**PW
) (
  input  logic CLK,
  input  logic reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Next-PC arithmetic gets two guard bits when bounds are checked: bit PW
  // catches overflow past the top, bit PW+1 marks a negative relative result.
`ifdef FETCH_BOUNDS_EN
  localparam int NW = PW + 2;
`else
  localparam int NW = PW;
`endif

  state_t        r_state;
  logic [PW-1:0] r_pc;
  logic [15:0]   r_count;

  logic [NW-1:0] w_off_ext;
  logic [NW-1:0] w_next_wide;
  logic [PW-1:0] w_next_pc;
  logic [15:0]   w_count_inc;

  assign w_off_ext   = {{(NW-OW){bus.offset[OW-1]}}, bus.offset};
  assign w_next_pc   = w_next_wide[PW-1:0];
  assign w_count_inc = (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;

  // Candidate next PC: absolute target, PC-relative, or sequential.
  always_comb begin
    w_next_wide = NW'(r_pc) + NW'(1);
    if (bus.branch_en && bus.branch_abs) begin
      w_next_wide = NW'(bus.target);
    end else if (bus.branch_en) begin
      w_next_wide = NW'(r_pc) + w_off_ext;
    end
  end

`ifdef FETCH_BOUNDS_EN
  logic r_fault;
  logic w_oob;

  assign w_oob     = w_next_wide[NW-1] || (w_next_wide >= NW'(PROG_LEN));
  assign bus.fault = r_fault;
`else
  assign bus.fault = 1'b0;
`endif

  // Sequencing FSM: IDLE -> RUN on start, RUN -> DONE on halt (or fault),
  // DONE -> RUN on start with a fresh PC and count.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= PW'(START_ADDR);
      r_count <= 16'd0;
`ifdef FETCH_BOUNDS_EN
      r_fault <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= PW'(START_ADDR);
          if (bus.start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (!bus.stall) begin
            if (bus.inst == HALT_INST) begin
              r_state <= S_DONE;
              r_count <= w_count_inc;
`ifdef FETCH_BOUNDS_EN
            end else if (w_oob) begin
              r_state <= S_DONE;
              r_fault <= 1'b1;
`endif
            end else begin
              r_pc    <= w_next_pc;
              r_count <= w_count_inc;
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_pc    <= PW'(START_ADDR);
            r_count <= 16'd0;
`ifdef FETCH_BOUNDS_EN
            r_fault <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.PC         = r_pc;
  assign bus.running    = (r_state == S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.inst_count = r_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter / instruction-fetch initiator that drives the PC address into the combinational instruction ROM and consumes the 9-bit instruction word it returns. Sequences execution from a start pulse: increment, absolute or PC-relative branch, stall, and halt detection. Reports run/done status and a retired-instruction count to the top-level testbench handshake.

Parameters:
PW, 16, PC / instruction-address width
OW, 8, width of signed relative-branch offset
START_ADDR, 0, PC value at reset and on every start
HALT_INST, 9'h1FF, instruction word that ends the program
PROG_LEN, 2**PW, number of valid instruction addresses (used only with FETCH_BOUNDS_EN)

Ports:
CLK  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high; sampled only on rising CLK
start  input  1  single-cycle pulse; begins or restarts the program
inst  input  9  instruction word from ROM at address PC (same cycle)
branch_en  input  1  decode: current instruction is a taken branch
branch_abs  input  1  1 = absolute target, 0 = relative offset
target  input  PW  absolute branch destination
offset  input  OW  signed two's-complement relative displacement
stall  input  1  hold current instruction; nothing retires
PC  output  PW  registered instruction address to ROM
running  output  1  state == RUN
done  output  1  state == DONE
inst_count  output  16  retired instructions, saturating at 16'hFFFF
fault  output  1  out-of-range fetch (tied 0 without FETCH_BOUNDS_EN)

Behaviour:
- Reset (sync, highest priority, any state): state=IDLE, PC=START_ADDR, inst_count=0, fault=0; running=0, done=0.
- States: IDLE, RUN, DONE; running/done decoded from state register, so they change the cycle after the causing edge.
- IDLE: PC held at START_ADDR. start=1 -> RUN; PC unchanged, so first executed instruction is the one at START_ADDR.
- RUN, per cycle, priority stall > halt > branch > increment:
  - stall=1: PC, count, state held; halt/branch ignored.
  - inst==HALT_INST: -> DONE, PC held, inst_count+1 (halt counts as retired).
  - branch_en & branch_abs: PC <= target; count+1.
  - branch_en & !branch_abs: PC <= PC + sign_extend(offset), modulo 2**PW; count+1.
  - else PC <= PC+1; 2**PW-1 wraps to 0; count+1.
  - start ignored in RUN.
- DONE: PC, count held; done=1. start=1 -> RUN, PC=START_ADDR, inst_count=0, fault=0.
- inst_count saturates at 16'hFFFF; never wraps.
- Single-cycle fetch: PC registered, ROM combinational, no bubbles; branch takes effect on next edge, no delay slot.
- Reset asserted mid-RUN: next edge returns to IDLE with reset values; in-flight instruction not counted.

Optional Feature:
FETCH_BOUNDS_EN: defined -> in RUN, if next PC (increment, absolute or relative, pre-wrap) >= PROG_LEN or relative sum over/underflows PW bits, instruction does not retire, PC held, fault=1, state -> DONE. fault cleared only by reset or start. Undefined -> no check, PC wraps modulo 2**PW, fault tied 0, PROG_LEN unused.

Test Plan:
1. reset 2 cycles, start pulse, inst=9'h000 -> PC sequence 0,0,1,2,3,4; running=1 from cycle after start; inst_count=4 after 4 RUN cycles.
2. At PC=3 branch_en=1 branch_abs=1 target=8 -> PC=8 next cycle; at PC=7 branch_en=1 branch_abs=0 offset=8'hFD -> PC=4.
3. Macro off: force relative branch to PC=16'hFFFF, next plain cycle -> PC=0, fault=0; offset=8'h80 at PC=5 -> PC=16'hFF85.
4. inst=HALT_INST at PC=9 after 9 retired -> next cycle done=1, running=0, PC=9, inst_count=10; start -> PC=0, count=0, running=1.
5. stall=1 three cycles at PC=2 with inst=HALT_INST -> PC=2, count unchanged, done=0; release -> done=1 next cycle.
6. reset at PC=5 during RUN -> next cycle PC=0, IDLE, count=0; macro on, PROG_LEN=10, absolute target=12 -> fault=1, done=1, PC unchanged.
